// File: rtl/cpu7_ifu_ibuf_pkg.sv
// Shared types for the fetch-to-decode instruction buffer.
// GRLEN and the exception-code width mirror the core-wide common definitions.
package cpu7_ifu_ibuf_pkg;
   localparam int unsigned GRLEN = 32;
   localparam int unsigned EXC_W = 6;

   typedef struct packed {
      logic [31:0]       inst;
      logic [GRLEN-1:0]  pc;
      logic              ex;
      logic [EXC_W-1:0]  exccode;
   } ibuf_entry_t;
endpackage

// File: rtl/cpu7_ifu_ibuf_if.sv
// Fetch-group input and decode-lane output bundle of the instruction buffer.
interface cpu7_ifu_ibuf_if #(
   parameter int unsigned FETCH_W = 4,
   parameter int unsigned ISSUE_W = 2
);
   import cpu7_ifu_ibuf_pkg::*;

   logic                               fdp_valid;
   logic                               fdp_ready;
   logic [GRLEN-1:0]                   fdp_pc;
   logic [$clog2(FETCH_W):0]           fdp_count;
   logic [FETCH_W-1:0][31:0]           fdp_rdata;
   logic                               fdp_ex;
   logic [EXC_W-1:0]                   fdp_exccode;

   logic [ISSUE_W-1:0]                 ibuf_dec_valid;
   logic [ISSUE_W-1:0][31:0]           ibuf_dec_inst;
   logic [ISSUE_W-1:0][GRLEN-1:0]      ibuf_dec_pc;
   logic [ISSUE_W-1:0]                 ibuf_dec_ex;
   logic [ISSUE_W-1:0][EXC_W-1:0]      ibuf_dec_exccode;
   logic [$clog2(ISSUE_W):0]           dec_accept;

   modport master (
      output fdp_valid, fdp_pc, fdp_count, fdp_rdata, fdp_ex, fdp_exccode, dec_accept,
      input  fdp_ready, ibuf_dec_valid, ibuf_dec_inst, ibuf_dec_pc, ibuf_dec_ex, ibuf_dec_exccode
   );

   modport slave (
      input  fdp_valid, fdp_pc, fdp_count, fdp_rdata, fdp_ex, fdp_exccode, dec_accept,
      output fdp_ready, ibuf_dec_valid, ibuf_dec_inst, ibuf_dec_pc, ibuf_dec_ex, ibuf_dec_exccode
   );
endinterface

// File: rtl/cpu7_ifu_ibuf_ram.sv
// Instruction buffer storage: FETCH_W write ports, ISSUE_W combinational read ports.
// Entries are never reset; the control logic never exposes an unwritten one.
module cpu7_ifu_ibuf_ram
   import cpu7_ifu_ibuf_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned FETCH_W = 4,
   parameter int unsigned ISSUE_W = 2
) (
   input  logic                                    clock,
   input  logic [FETCH_W-1:0]                      we,
   input  logic [FETCH_W-1:0][$clog2(DEPTH)-1:0]   waddr,
   input  ibuf_entry_t [FETCH_W-1:0]               wdata,
   input  logic [ISSUE_W-1:0][$clog2(DEPTH)-1:0]   raddr,
   output ibuf_entry_t [ISSUE_W-1:0]               rdata
);
   ibuf_entry_t mem [DEPTH];

   // Write addresses within one group are consecutive modulo DEPTH, hence distinct.
   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < FETCH_W; i++) begin
         if (we[i]) mem[waddr[i]] <= wdata[i];
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < ISSUE_W; i++) begin
         rdata[i] = mem[raddr[i]];
      end
   end
endmodule

// File: rtl/cpu7_ifu_ibuf.sv
// Circular instruction buffer between fetch and decode: pointers, occupancy,
// exception gating of decode lanes and the lane output mux.
module cpu7_ifu_ibuf
   import cpu7_ifu_ibuf_pkg::*;
#(
   parameter int unsigned FETCH_W = 4,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned ISSUE_W = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    stall,
   output logic [$clog2(DEPTH):0]  ibuf_count,
   cpu7_ifu_ibuf_if.slave          bus
);
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned FCW = $clog2(FETCH_W) + 1;

   logic [AW-1:0]                rptr, wptr;
   logic [CW-1:0]                count, wr_num, rd_num, lane_num;
   logic                         ready, do_write, blocked;
   logic [FETCH_W-1:0]           we;
   logic [FETCH_W-1:0][AW-1:0]   waddr;
   ibuf_entry_t [FETCH_W-1:0]    wdata;
   logic [ISSUE_W-1:0][AW-1:0]   raddr;
   ibuf_entry_t [ISSUE_W-1:0]    rdata;
   logic [ISSUE_W-1:0]           lane_valid;

   assign ready    = (count <= CW'(DEPTH - FETCH_W));
   assign do_write = bus.fdp_valid & ready & ~flush;

   // Exception groups collapse to one entry; out-of-range counts are clamped.
   always_comb begin
      if (!do_write)                               wr_num = '0;
      else if (bus.fdp_ex)                         wr_num = CW'(1);
      else if (bus.fdp_count > FCW'(FETCH_W))      wr_num = CW'(FETCH_W);
      else                                         wr_num = CW'(bus.fdp_count);
   end

   always_comb begin
      for (int unsigned i = 0; i < FETCH_W; i++) begin
         we[i]            = (CW'(i) < wr_num);
         waddr[i]         = wptr + AW'(i);
         wdata[i].inst    = bus.fdp_rdata[i];
         wdata[i].pc      = bus.fdp_pc + GRLEN'(4 * i);
         wdata[i].ex      = bus.fdp_ex;
         wdata[i].exccode = bus.fdp_ex ? bus.fdp_exccode : '0;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < ISSUE_W; i++) raddr[i] = rptr + AW'(i);
   end

   cpu7_ifu_ibuf_ram #(
      .DEPTH   (DEPTH),
      .FETCH_W (FETCH_W),
      .ISSUE_W (ISSUE_W)
   ) u_ram (
      .clock (clock),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   // A lane is valid only while no earlier lane carries an exception.
   always_comb begin
      blocked  = 1'b0;
      lane_num = '0;
      for (int unsigned i = 0; i < ISSUE_W; i++) begin
         lane_valid[i] = ~reset & ~blocked & (count > CW'(i));
         blocked       = blocked | (lane_valid[i] & rdata[i].ex);
         lane_num      = lane_num + CW'(lane_valid[i]);
      end
   end

   always_comb begin
      if (stall || flush)                     rd_num = '0;
      else if (CW'(bus.dec_accept) < lane_num) rd_num = CW'(bus.dec_accept);
      else                                     rd_num = lane_num;
   end

   always_comb begin
      for (int unsigned i = 0; i < ISSUE_W; i++) begin
         bus.ibuf_dec_valid[i]   = lane_valid[i];
         bus.ibuf_dec_inst[i]    = lane_valid[i] ? rdata[i].inst    : '0;
         bus.ibuf_dec_pc[i]      = lane_valid[i] ? rdata[i].pc      : '0;
         bus.ibuf_dec_ex[i]      = lane_valid[i] ? rdata[i].ex      : 1'b0;
         bus.ibuf_dec_exccode[i] = lane_valid[i] ? rdata[i].exccode : '0;
      end
   end

   assign bus.fdp_ready = reset | ready;
   assign ibuf_count    = reset ? '0 : count;

   always_ff @(posedge clock) begin
      if (reset) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else if (flush) begin
         rptr  <= wptr;
         count <= '0;
      end else begin
         wptr  <= wptr + AW'(wr_num);
         rptr  <= rptr + AW'(rd_num);
         count <= count + wr_num - rd_num;
      end
   end
endmodule
